cv32e40p_apu_arbiter: RTL

//  Shares one APU/FPU instance (cv32e40p_fp_wrapper) between NUM_REQ core APU ports.

---
 rtl/cv32e40p_apu_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_apu_arbiter.sv
// cv32e40p_apu_arbiter: shares one APU/FPU between NUM_REQ core APU ports.
// Round-robin pick, locked while waiting for the FPU grant; in-order ID FIFO
// steers each FPU result back to the core that issued it.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i/operands_i/op_i/flags_i   per-core APU request bundle
//   gnt_o, rvalid_o     per-core grant / result valid (one-hot or zero)
//   rdata_o, rflags_o   shared result data / flags
//   fpu_*_o, fpu_*_i    muxed request to / result from the FPU wrapper
//   err_o               sticky protocol error
//   conflict_cnt_o      saturating conflict counter
//
// Optional feature: define CV32E40P_APU_ARB_PERF_EN to build the conflict
// counter; otherwise conflict_cnt_o is tied to zero.

module cv32e40p_apu_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int APU_NARGS       = 3,
  parameter int APU_WOP         = 6,
  parameter int APU_NDSFLAGS    = 15,
  parameter int APU_NUSFLAGS    = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,

  input  logic [NUM_REQ-1:0]                      req_i,
  input  logic [NUM_REQ-1:0][APU_NARGS-1:0][31:0] operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP-1:0]         op_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS-1:0]    flags_i,
  output logic [NUM_REQ-1:0]                      gnt_o,
  output logic [NUM_REQ-1:0]                      rvalid_o,
  output logic [31:0]                             rdata_o,
  output logic [APU_NUSFLAGS-1:0]                 rflags_o,

  output logic                                    fpu_req_o,
  output logic [APU_NARGS-1:0][31:0]              fpu_operands_o,
  output logic [APU_WOP-1:0]                      fpu_op_o,
  output logic [APU_NDSFLAGS-1:0]                 fpu_flags_o,
  input  logic                                    fpu_gnt_i,
  input  logic                                    fpu_rvalid_i,
  input  logic [31:0]                             fpu_rdata_i,
  input  logic [APU_NUSFLAGS-1:0]                 fpu_rflags_i,

  output logic                                    err_o,
  output logic [15:0]                             conflict_cnt_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;

  typedef logic [PW-1:0] id_t;

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e              state_q;
  id_t                 lock_q;
  id_t                 rr_q;
  logic                err_q;

  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [AW-1:0]       wptr_q;
  logic [AW-1:0]       rptr_q;
  id_t                 mem_q [MAX_OUTSTANDING];

  logic [2*NUM_REQ-1:0] req2;
  logic [NUM_REQ-1:0]   rot;
  int                   off;
  int                   sum;
  id_t                  rr_sel;
  id_t                  sel;
  id_t                  sel_nxt;
  id_t                  head;
  logic                 req_sel;
  logic                 empty;
  logic                 full;
  logic                 full_eff;
  logic                 pop;
  logic                 push;
  logic                 hs;
  logic                 lock_drop;
  logic                 orphan;

  // Rotate the request vector so bit 0 is the rr pointer, then take the
  // lowest set bit and rotate the offset back.
  always_comb begin
    req2   = {req_i, req_i};
    rot    = req2[rr_q +: NUM_REQ];
    off    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum    = int'(rr_q) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    rr_sel = id_t'(sum);
  end

  assign sel     = (state_q == LOCK) ? lock_q : rr_sel;
  assign sel_nxt = (sel == id_t'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  assign req_sel = req_i[sel];

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign pop   = fpu_rvalid_i & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign full_eff = full & ~pop;
  assign head     = mem_q[rptr_q];

  assign fpu_req_o = req_sel & ~full_eff;
  assign hs        = fpu_req_o & fpu_gnt_i;
  assign push      = hs;

  assign gnt_o    = hs  ? (ONE_HOT0 << sel)  : '0;
  assign rvalid_o = pop ? (ONE_HOT0 << head) : '0;
  assign rdata_o  = fpu_rdata_i;
  assign rflags_o = fpu_rflags_i;

  assign fpu_operands_o = req_sel ? operands_i[sel] : '0;
  assign fpu_op_o       = req_sel ? op_i[sel]       : '0;
  assign fpu_flags_o    = req_sel ? flags_i[sel]    : '0;

  assign lock_drop = (state_q == LOCK) & ~req_i[lock_q];
  assign orphan    = fpu_rvalid_i & empty;
  assign err_o     = err_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | lock_drop | orphan;
      if (push) begin
        rr_q   <= sel_nxt;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (|req_i && !fpu_gnt_i && !full_eff) begin
            state_q <= LOCK;
            lock_q  <= rr_sel;
          end
        end
        LOCK: begin
          if (lock_drop || hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= sel;
  end

`ifdef CV32E40P_APU_ARB_PERF_EN
  logic [15:0]        conf_q;
  logic               multi;

  assign multi = |(req_i & (req_i - NUM_REQ'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conf_q <= '0;
    end else if (multi && hs && conf_q != 16'hFFFF) begin
      conf_q <= conf_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conf_q;
`else
  assign conflict_cnt_o = 16'h0;
`endif

endmodule
